gray2bin_seq: RTL and testbench

Sequential Gray-to-binary decoder, the inverse of the combinational bin2gray converter. It accepts a WIDTH-bit Gray code word over a valid/ready handshake. It then resolves the binary value MSB-first, STEP bits per clock, and presents the result on an output valid/ready handshake. It serves as the decode end of Gray-coded paths such as pointers and position counters.

---
 rtl/gray2bin_seq.sv | 147 ++++++++++++++
 tb/tb_gray2bin_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gray2bin_seq.sv
// -----------------------------------------------------------------------------
// gray2bin_seq
//
// Sequential Gray-to-binary decoder. It accepts one WIDTH-bit Gray word on an
// input handshake and resolves the binary value MSB-first, STEP bits per
// clock. It then holds the result on an output handshake until the result is
// taken.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. A source holds its data stable while valid
// is 1 and ready is 0. Valid does not depend on ready.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   gray_in holds a valid word
//   in_ready   out  block is idle and can accept a word
//   gray_in    in   Gray-coded input word (WIDTH bits)
//   out_valid  out  bin_out holds a valid result
//   out_ready  in   downstream accepts the result
//   bin_out    out  decoded binary word (WIDTH bits)
//   busy       out  decode in progress
//   dbg_state  out  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module gray2bin_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int NSTEP = WIDTH / STEP;
    // One spare bit so the counter can never wrap inside a word.
    localparam int CW    = $clog2(NSTEP) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] r_bin;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic             w_last;
    int               w_shift;
    logic [STEP-1:0]  w_gslice;
    logic [STEP-1:0]  w_bslice;
    logic [WIDTH-1:0] w_bin_nxt;

    // Slice k covers bits [WIDTH-1-k*STEP : WIDTH-(k+1)*STEP]. Its LSB sits
    // at (NSTEP-1-k)*STEP.
    always_comb begin
        w_shift   = 0;
        w_gslice  = '0;
        w_bin_nxt = r_bin;
        w_shift   = (NSTEP - 1 - int'(r_cnt)) * STEP;
        w_gslice  = STEP'(r_gray >> w_shift);
        // r_bin is cleared on capture, so OR-ing each slice into place is enough.
        w_bin_nxt = r_bin | (WIDTH'(w_bslice) << w_shift);
    end

    // XOR chain across one slice. The carry is the last bit resolved in the
    // previous slice, which is 0 for the first slice.
    always_comb begin : slice_decode
        logic v_c;
        w_bslice = '0;
        v_c      = r_carry;
        for (int j = STEP - 1; j >= 0; j--) begin
            v_c         = v_c ^ w_gslice[j];
            w_bslice[j] = v_c;
        end
    end

    assign w_last = (r_cnt == CW'(NSTEP - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gray      <= '0;
            r_bin       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // The handshake flags are decoded from the next state. This keeps
            // them aligned with the state register and still fully registered.
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt == S_BUSY);
            r_out_valid <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_gray  <= gray_in;
                        r_bin   <= '0;
                        r_cnt   <= '0;
                        r_carry <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_bin   <= w_bin_nxt;
                    r_carry <= w_bslice[0];
                    r_cnt   <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign bin_out   = r_bin;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gray2bin_seq.sv
module tb_gray2bin_seq;

  localparam int W  = 32;
  localparam int NU = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [NU];
  logic         in_ready  [NU];
  logic [W-1:0] gray_in   [NU];
  logic         out_valid [NU];
  logic         out_ready [NU];
  logic [W-1:0] bin_out   [NU];
  logic         busy      [NU];
  logic [1:0]   dbg_state [NU];

  // Instance 0: STEP=4, instance 1: STEP=1, instance 2: STEP=32.
  int lat [NU] = '{8, 32, 1};

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    localparam int S = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
    gray2bin_seq #(.WIDTH(W), .STEP(S)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .gray_in   (gray_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .bin_out   (bin_out[g]),
      .busy      (busy[g]),
      .dbg_state (dbg_state[g])
    );
  end

  // reference model: bin[i] is the XOR reduction of gray[W-1:i]
  function automatic logic [W-1:0] ref_decode(input logic [W-1:0] g);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = ^(g >> i);
    return r;
  endfunction

  // scoreboard
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one full word through instance u.
  // noise=1 wiggles in_valid/gray_in/out_ready while the word is decoding.
  // hold = cycles of backpressure once out_valid is up.
  task automatic xfer(input int u, input logic [W-1:0] g, input bit noise, input int hold);
    int n;
    logic [W-1:0] exp;
    exp_q.push_back(ref_decode(g));
    n = 0;
    while (!in_ready[u] && n < 100) begin tick(); n++; end
    check("in_ready_pre", W'(in_ready[u]), 1);
    in_valid[u] = 1'b1;
    gray_in[u]  = g;
    tick();
    in_valid[u] = 1'b0;
    check("in_ready_drop", W'(in_ready[u]), 0);
    check("busy_set", W'(busy[u]), 1);
    check("state_busy", W'(dbg_state[u]), 1);
    n = 0;
    while (!out_valid[u] && n < 200) begin
      if (noise) begin
        in_valid[u]  = 1'($urandom_range(0, 1));
        gray_in[u]   = $urandom;
        out_ready[u] = 1'($urandom_range(0, 1));
      end
      tick();
      n++;
    end
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
    exp = exp_q.pop_front();
    check("latency", W'(n), W'(lat[u]));
    check("out_valid", W'(out_valid[u]), 1);
    check("busy_clear", W'(busy[u]), 0);
    check("state_done", W'(dbg_state[u]), 2);
    check("bin_out", bin_out[u], exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", W'(out_valid[u]), 1);
      check("hold_data", bin_out[u], exp);
      check("hold_in_ready", W'(in_ready[u]), 0);
    end
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
    check("out_valid_drop", W'(out_valid[u]), 0);
    check("in_ready_rise", W'(in_ready[u]), 1);
    check("bin_keep", bin_out[u], exp);
  endtask

  task automatic round_trip(input int u, input int words);
    logic [W-1:0] b;
    for (int k = 0; k < words; k++) begin
      b = $urandom;
      // The decoded word is expected to equal b; ref_decode must agree too.
      check("rt_model", ref_decode(b ^ (b >> 1)), b);
      xfer(u, b ^ (b >> 1), 1'b0, 0);
    end
  endtask

  initial begin
    void'($urandom(0));
    rst_n = 1'b0;
    for (int u = 0; u < NU; u++) begin
      in_valid[u]  = 1'b0;
      gray_in[u]   = '0;
      out_ready[u] = 1'b0;
    end
    tick();
    tick();
    for (int u = 0; u < NU; u++) begin
      check("rst_in_ready", W'(in_ready[u]), 1);
      check("rst_out_valid", W'(out_valid[u]), 0);
      check("rst_busy", W'(busy[u]), 0);
      check("rst_bin_out", bin_out[u], 0);
      check("rst_state", W'(dbg_state[u]), 0);
    end
    rst_n = 1'b1;
    tick();

    // directed words
    xfer(0, 32'h0000_0001, 1'b0, 0);
    check("dir_1", ref_decode(32'h0000_0001), 32'h0000_0001);
    xfer(0, 32'h8000_0000, 1'b0, 0);
    check("dir_msb", ref_decode(32'h8000_0000), 32'hFFFF_FFFF);
    xfer(0, 32'hFFFF_FFFF, 1'b0, 0);
    check("dir_ones", ref_decode(32'hFFFF_FFFF), 32'hAAAA_AAAA);
    xfer(0, 32'h0000_0003, 1'b0, 0);
    check("dir_3", ref_decode(32'h0000_0003), 32'h0000_0002);

    // backpressure for 20 cycles
    xfer(0, 32'h1234_5678, 1'b0, 20);

    // ignored input / out_ready during decode
    for (int u = 0; u < NU; u++) begin
      xfer(u, $urandom, 1'b1, 0);
      xfer(u, $urandom, 1'b1, 3);
    end

    // reset in the middle of a decode
    while (!in_ready[0]) tick();
    in_valid[0] = 1'b1;
    gray_in[0]  = 32'h8000_0000;
    tick();
    in_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    check("mid_partial", W'(bin_out[0] != 0), 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", W'(out_valid[0]), 0);
    check("mid_rst_busy", W'(busy[0]), 0);
    check("mid_rst_ready", W'(in_ready[0]), 1);
    check("mid_rst_bin", bin_out[0], 0);
    check("mid_rst_state", W'(dbg_state[0]), 0);
    rst_n = 1'b1;
    tick();
    xfer(0, 32'h0F0F_F0F0, 1'b0, 0);

    // randomized round trips
    round_trip(0, 1500);
    round_trip(1, 500);
    round_trip(2, 1500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
